// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-port multiplier arbiter.
package mul_arb_pkg;

    localparam int MUL_W          = 32;
    localparam int MUL_STEPS      = 33;
    localparam int DEFAULT_MAXCYC = 40;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RELEASE
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side multiply port: request with operands, one-cycle ack with held result.
interface mul_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int W = MUL_W
);

    logic           req;
    logic           u;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           ack;
    logic [2*W-1:0] z;

    modport master (output req, u, x, y, input ack, z);
    modport slave  (input req, u, x, y, output ack, z);

endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a grant is taken.
module rr_arb2
    import mul_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       valid,
    output logic       idx
);

    logic last;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid = |req;
        idx   = PORT_A;
        if (req == 2'b11) begin
            idx = ~last;
        end else if (req[PORT_B]) begin
            idx = PORT_B;
        end
    end

    // Reset to B so that the first tie resolves to A.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= PORT_B;
        end else if (update) begin
            last <= idx;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Time-shares one iterative run/stall multiplier between ports A and B,
// with a watchdog that aborts a run the multiplier never finishes.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int W      = MUL_W,
    parameter int MAXCYC = DEFAULT_MAXCYC
) (
    input  logic           clk,
    input  logic           rst,
    mul_arbiter_if.slave   a,
    mul_arbiter_if.slave   b,
    output logic           m_run,
    output logic           m_u,
    output logic [W-1:0]   m_x,
    output logic [W-1:0]   m_y,
    input  logic           m_stall,
    input  logic [2*W-1:0] m_z,
    output logic           busy,
    output logic           owner,
    output logic           err
);

    localparam int CW = $clog2(MAXCYC + 1);

    state_t        state;
    state_t        state_next;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          grant;
    logic          done;
    logic          abort;
    logic [CW-1:0] wd_cnt;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({b.req, a.req}),
        .update (grant),
        .valid  (gnt_valid),
        .idx    (gnt_idx)
    );

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!m_stall) begin
                    done       = 1'b1;
                    state_next = RELEASE;
                end else if (wd_cnt == CW'(MAXCYC - 1)) begin
                    abort      = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // m_run follows the state directly; RELEASE gives the multiplier one low cycle to clear.
    assign m_run = (state == RUN);
    assign busy  = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_u    <= 1'b0;
            m_x    <= '0;
            m_y    <= '0;
            owner  <= PORT_A;
            err    <= 1'b0;
            wd_cnt <= '0;
            a.ack  <= 1'b0;
            b.ack  <= 1'b0;
            a.z    <= '0;
            b.z    <= '0;
        end else begin
            a.ack <= 1'b0;
            b.ack <= 1'b0;
            if (grant) begin
                owner  <= gnt_idx;
                wd_cnt <= '0;
                if (gnt_idx == PORT_B) begin
                    m_u <= b.u;
                    m_x <= b.x;
                    m_y <= b.y;
                end else begin
                    m_u <= a.u;
                    m_x <= a.x;
                    m_y <= a.y;
                end
            end
            if (state == RUN) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (abort) begin
                err <= 1'b1;
            end
            if (done) begin
                if (owner == PORT_B) begin
                    b.z   <= m_z;
                    b.ack <= 1'b1;
                end else begin
                    a.z   <= m_z;
                    a.ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized and directed bench for mul_arbiter against a cycle-count/round-robin reference model.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        m_run;
    logic        m_u;
    logic [31:0] m_x;
    logic [31:0] m_y;
    logic        m_stall;
    logic [63:0] m_z;
    logic        busy;
    logic        owner;
    logic        err;

    mul_arbiter_if ai ();
    mul_arbiter_if bi ();

    mul_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .a       (ai),
        .b       (bi),
        .m_run   (m_run),
        .m_u     (m_u),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_stall (m_stall),
        .m_z     (m_z),
        .busy    (busy),
        .owner   (owner),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Multiplier stub: stall stays high until MUL_STEPS cycles of run, or forever when stuck.
    logic stuck;
    int   run_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)       run_cnt <= 0;
        else if (m_run) run_cnt <= run_cnt + 1;
        else            run_cnt <= 0;
    end
    assign m_stall = stuck || (run_cnt != MUL_STEPS);
    always_comb begin
        if (m_u) m_z = $signed(m_x) * $signed(m_y);
        else     m_z = {32'b0, m_x} * {32'b0, m_y};
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        last_g;
    logic [63:0] prev_az;
    logic [63:0] prev_bz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic u, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (u) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return 64'(x) * 64'(y);
    endfunction

    // One arbitration round: ops issue at cycle 0, each takes 36 cycles, ack 35 cycles after its grant.
    task automatic do_round(input logic ra, input logic rb, input logic au, input logic bu,
                            input logic [31:0] ax, input logic [31:0] ay,
                            input logic [31:0] bx, input logic [31:0] by, input int a_drop);
        logic        first;
        int          ea, eb, got_a, got_b, runs, extra, win, t0, rel;
        logic [63:0] exp_az, exp_bz;
        ea = -1;
        eb = -1;
        if (ra && rb) begin
            first  = ~last_g;
            ea     = (first == PORT_A) ? 35 : 71;
            eb     = (first == PORT_B) ? 35 : 71;
            last_g = ~first;
        end else if (ra) begin
            ea     = 35;
            last_g = PORT_A;
        end else begin
            eb     = 35;
            last_g = PORT_B;
        end
        exp_az = ra ? ref_mul(au, ax, ay) : prev_az;
        exp_bz = rb ? ref_mul(bu, bx, by) : prev_bz;
        win    = (ra && rb) ? 73 : 37;

        @(negedge clk);
        ai.req = ra; ai.u = au; ai.x = ax; ai.y = ay;
        bi.req = rb; bi.u = bu; bi.x = bx; bi.y = by;
        t0 = cyc;
        got_a = -1; got_b = -1; runs = 0; extra = 0;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (m_run) runs++;
            if (ai.ack) begin
                if (got_a < 0) got_a = rel; else extra++;
                ai.req = 1'b0;
            end
            if (bi.ack) begin
                if (got_b < 0) got_b = rel; else extra++;
                bi.req = 1'b0;
            end
            if (rel == a_drop) ai.req = 1'b0;
        end
        check("a_ack_cycle", 64'(got_a), 64'(ea));
        check("b_ack_cycle", 64'(got_b), 64'(eb));
        check("extra_acks", 64'(extra), 64'd0);
        check("run_cycles", 64'(runs), 64'(34 * (int'(ra) + int'(rb))));
        check("a_z", ai.z, exp_az);
        check("b_z", bi.z, exp_bz);
        check("owner", 64'(owner), 64'(last_g));
        check("busy_idle", 64'(busy), 64'd0);
        prev_az = exp_az;
        prev_bz = exp_bz;
    endtask

    initial begin
        int t0, rel, runs, acks, err_at;
        logic [2:0] sel;

        rst = 1'b0; stuck = 1'b0;
        ai.req = 1'b0; ai.u = 1'b0; ai.x = '0; ai.y = '0;
        bi.req = 1'b0; bi.u = 1'b0; bi.x = '0; bi.y = '0;
        last_g = PORT_B; prev_az = '0; prev_bz = '0;
        repeat (3) @(negedge clk);
        check("rst_m_run", 64'(m_run), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_m_ops", {31'b0, m_u, m_x}, 64'd0);
        check("rst_acks", 64'({ai.ack, bi.ack}), 64'd0);
        check("rst_z", ai.z | bi.z, 64'd0);
        rst = 1'b1;

        // First tie after reset goes to A, then the pointer alternates.
        do_round(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6, -1);
        check("tie_a_z", ai.z, 64'd12);
        check("tie_b_z", bi.z, 64'd30);
        do_round(1'b1, 1'b1, 1'b0, 1'b0, 32'd8, 32'd9, 32'd10, 32'd11, -1);
        do_round(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFF0, -1);

        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, -1);
        check("a_7x6", ai.z, 64'd42);
        do_round(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, -1);
        check("a_signed", ai.z, 64'hFFFFFFFFFFFFFFF1);
        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, -1);
        check("a_unsigned", ai.z, 64'h00000004FFFFFFF1);

        // A withdraws its request mid-operation; the result is still delivered.
        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd100000, 32'd3000, 32'd0, 32'd0, 5);
        check("a_drop_z", ai.z, 64'd300000000);

        for (int k = 0; k < 8; k++) begin
            sel = 3'($urandom_range(1, 3));
            do_round(sel[0], sel[1], 1'($urandom), 1'($urandom),
                     $urandom, $urandom, $urandom, $urandom, -1);
        end

        // Asynchronous reset in the tenth cycle of a run.
        @(negedge clk);
        ai.req = 1'b1; ai.u = 1'b0; ai.x = 32'd11; ai.y = 32'd13;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        ai.req = 1'b0;
        #1;
        check("arst_m_run", 64'(m_run), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_acks", 64'({ai.ack, bi.ack}), 64'd0);
        check("arst_z", ai.z | bi.z, 64'd0);
        check("arst_m_x", 64'(m_x), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ai.ack || bi.ack) acks++;
        end
        check("arst_no_ack", 64'(acks), 64'd0);
        last_g = PORT_B; prev_az = '0; prev_bz = '0;
        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 32'd0, -1);
        check("arst_fresh_z", ai.z, 64'd143);

        // Watchdog: the multiplier never lowers stall.
        stuck = 1'b1;
        @(negedge clk);
        ai.req = 1'b1; ai.u = 1'b0; ai.x = 32'd9; ai.y = 32'd9;
        t0 = cyc; runs = 0; acks = 0; err_at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (m_run) runs++;
            if (ai.ack || bi.ack) acks++;
            if (err && err_at < 0) err_at = rel;
            if (!m_run && runs > 0) ai.req = 1'b0;
        end
        check("wd_run_cycles", 64'(runs), 64'(DEFAULT_MAXCYC));
        check("wd_err_cycle", 64'(err_at), 64'(DEFAULT_MAXCYC + 1));
        check("wd_no_ack", 64'(acks), 64'd0);
        check("wd_z_kept", ai.z, prev_az);
        last_g = PORT_A;
        stuck = 1'b0;
        do_round(1'b1, 1'b1, 1'b0, 1'b1, 32'd21, 32'd2, 32'hFFFFFFFE, 32'd9, -1);
        check("wd_err_sticky", 64'(err), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Sequences the shared 32-bit iterative multiplier (run/stall protocol, 64-bit product) and time-shares it between two requesters: port A (CPU core) and port B (auxiliary unit, e.g. graphics/DMA).
- Latches the granted requester's operands, holds run until stall falls, captures the product, and returns it with a one-cycle ack.
- Sits between the requesters and the multiplier instance; the multiplier itself is unmodified.

Parameters:
- W, 32, operand width; product width is 2*W.
- MAXCYC, 40, watchdog limit in cycles of m_run high; exceeding it aborts the operation and sets err.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  A requests a multiply; held with operands until a_ack.
- a_u  in  1  A signed select (1 = signed).
- a_x, a_y  in  W  A operands.
- a_ack  out  1  one-cycle pulse: A's result is valid.
- a_z  out  2W  A result register; holds until the next A completion.
- b_req, b_u, b_x, b_y, b_ack, b_z  same as the A ports, for B.
- m_run  out  1  multiplier run.
- m_u  out  1  multiplier signed select.
- m_x, m_y  out  W  multiplier operands; registered, stable for the whole operation.
- m_stall  in  1  multiplier stall.
- m_z  in  2W  multiplier product.
- busy  out  1  state != IDLE.
- owner  out  1  current/last grant (0 = A, 1 = B).
- err  out  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- Reset (async, rst=0): state IDLE; m_run=0; m_u=0; m_x=m_y=0; a_ack=b_ack=0; a_z=b_z=0; busy=0; owner=0; err=0; round-robin pointer favours A.
- States: IDLE, RUN, RELEASE.
- IDLE:
  - If any req is sampled, grant per round robin.
  - Latch the granted port's u/x/y into m_u/m_x/m_y, set owner, go to RUN with m_run=1 from the next cycle.
  - With no req, remain IDLE and keep m_run=0.
- Round robin:
  - Only one req high: grant that port.
  - Both high: grant the port not granted last time.
  - First tie after reset goes to A.
- RUN:
  - Hold m_run=1 and increment the watchdog counter each cycle.
  - When m_stall==0 is sampled: copy m_z into a_z or b_z (per owner), pulse the matching ack for exactly one cycle, drop m_run, go to RELEASE.
- RELEASE:
  - Exactly one cycle with m_run=0 so the multiplier step counter clears, then go to IDLE.
  - A req pending at this point is granted in the following IDLE cycle.
- Latency with the standard multiplier (stall falls after 33 cycles of run):
  - Req first sampled in IDLE at cycle 0.
  - m_run high in cycles 1..34.
  - ack in cycle 35.
  - Back-to-back operations occupy 36 cycles each.
- Watchdog: if the counter reaches MAXCYC with m_stall still 1, set err, drop m_run, go to RELEASE. No ack is issued, the result register is unchanged, and the pointer still advances.
- Requester drops req mid-operation: the operation completes, the result is stored, and ack still pulses.
- A req rising during another port's operation waits; no starvation, since the other port cannot win twice in a row while both request.
- m_x/m_y/m_u change only on a grant, never during RUN.
- Results are stored as delivered by the multiplier (2W bits, no truncation). Signedness is entirely the multiplier's function of m_u.

Decomposition:
- Package mul_arb_pkg holds:
  - the state enum {IDLE, RUN, RELEASE};
  - constants MUL_W=32 and MUL_STEPS=33;
  - default MAXCYC;
  - port-index constants PORT_A=0, PORT_B=1.
- One natural sub-module: rr_arb2 (2-way round-robin grant with last-grant pointer, update-on-grant input).

Test Plan:
- A only, u=0, x=7, y=6 -> m_run high in cycles 1..34, a_ack in cycle 35, a_z=64'd42, b_ack never asserts.
- A only, u=1, x=32'hFFFFFFFD (-3), y=5 -> a_z=64'hFFFFFFFFFFFFFFF1 (-15); with u=0, same operands -> a_z=64'h00000004FFFFFFF1.
- A and B raised together (A: 3×4, B: 5×6) -> A granted first (a_z=12, ack cycle 35), one RELEASE cycle, B granted (b_z=30, ack cycle 71); repeat tie -> B first this time.
- Both held continuously for four operations -> grants alternate A,B,A,B; m_run low exactly one cycle between operations.
- rst driven low in cycle 10 of RUN -> m_run, busy, acks and results 0 immediately (asynchronously), with no ack afterward; a fresh A request then completes normally.
- Multiplier stub with m_stall stuck at 1 -> err set after MAXCYC=40 cycles, m_run dropped, no ack, next request still served and err stays 1.
